// File: rtl/sequence_111_if.sv
// Serial "111" detector signal bundle: one data bit in, one detect flag out.
// The master drives the serial stream; the slave is the detector.
interface sequence_111_if;
    logic din;
    logic dout;

    modport master (
        output din,
        input  dout
    );

    modport slave (
        input  din,
        output dout
    );
endinterface : sequence_111_if

// File: rtl/sequence_111.sv
// sequence_111: Moore FSM that flags three consecutive 1s on a serial input.
// OVERLAP=1 keeps the flag high for every further 1 of a run.
// OVERLAP=0 restarts counting after each match, so each disjoint group of three 1s
// produces one pulse.
// The detect flag is a flop loaded from the next state, so `out` always equals
// (state == S3). There is no combinational path from `in` to `out`.
module sequence_111 #(
    parameter int OVERLAP = 1
) (
    input  logic in,
    output logic out,
    input  logic clk,
    input  logic rst
);

    typedef enum logic [1:0] {
        S0 = 2'b00,   // no 1s pending
        S1 = 2'b01,   // one 1 seen
        S2 = 2'b10,   // two consecutive 1s seen
        S3 = 2'b11    // match
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_out;

    // State and detect-flag registers; synchronous reset has priority over every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= (w_next == S3);
        end
    end

    // Next-state logic: a sampled 0 always returns to S0; unknown encodings recover to S0
    always_comb begin
        w_next = S0;
        case (r_state)
            S0: begin
                if (in) begin
                    w_next = S1;
                end else begin
                    w_next = S0;
                end
            end
            S1: begin
                if (in) begin
                    w_next = S2;
                end else begin
                    w_next = S0;
                end
            end
            S2: begin
                if (in) begin
                    w_next = S3;
                end else begin
                    w_next = S0;
                end
            end
            S3: begin
                if (in) begin
                    if (OVERLAP != 0) begin
                        w_next = S3;
                    end else begin
                        w_next = S1;
                    end
                end else begin
                    w_next = S0;
                end
            end
            default: begin
                w_next = S0;
            end
        endcase
    end

    assign out = r_out;

endmodule : sequence_111

// File: tb/tb_sequence_111.sv
// Testbench for sequence_111: drives overlapping and non-overlapping instances
// with the same stream. Expected flags come from a run-length model: a queue entry
// is pushed when a bit is driven and popped after the sampling edge.
`timescale 1ns/1ps
module tb_sequence_111;

    logic clk;
    logic rst;

    sequence_111_if if_ov ();
    sequence_111_if if_nov ();

    sequence_111 #(.OVERLAP(1)) u_ov (
        .in  (if_ov.din),
        .out (if_ov.dout),
        .clk (clk),
        .rst (rst)
    );

    sequence_111 #(.OVERLAP(0)) u_nov (
        .in  (if_nov.din),
        .out (if_nov.dout),
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        logic  ov;
        logic  nov;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit, predict both flags from the current run of 1s, then check after the edge
    task automatic step(input logic b_in, input logic b_rst, input string tag);
        exp_t e;
        @(negedge clk);
        if_ov.din  = b_in;
        if_nov.din = b_in;
        rst        = b_rst;
        if (b_rst) begin
            run_len = 0;
        end else if (b_in) begin
            run_len = run_len + 1;
        end else begin
            run_len = 0;
        end
        e.ov  = (run_len >= 3) ? 1'b1 : 1'b0;
        e.nov = (run_len != 0 && (run_len % 3) == 0) ? 1'b1 : 1'b0;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks = checks + 1;
        assert (if_ov.dout === e.ov)
        else begin
            errors = errors + 1;
            $error("FAIL %s ov: observed %b expected %b", e.tag, if_ov.dout, e.ov);
        end
        checks = checks + 1;
        assert (if_nov.dout === e.nov)
        else begin
            errors = errors + 1;
            $error("FAIL %s nov: observed %b expected %b", e.tag, if_nov.dout, e.nov);
        end
    endtask

    initial begin
        logic [13:0] basic;
        logic [5:0]  near;
        rst        = 1'b1;
        if_ov.din  = 1'b1;
        if_nov.din = 1'b1;

        // Reset held two cycles with in=1: out stays 0
        step(1'b1, 1'b1, "reset0");
        step(1'b1, 1'b1, "reset1");

        // Basic stream 1,0,1,1,1,0,1,1,0,1,1,1,1,0 (MSB first)
        basic = 14'b10111011011110;
        for (int i = 13; i >= 0; i--) begin
            step(basic[i], 1'b0, "basic");
        end

        // Near miss 1,1,0,1,1,0: never matches
        near = 6'b110110;
        for (int i = 5; i >= 0; i--) begin
            step(near[i], 1'b0, "near_miss");
        end

        // Long run of six 1s
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, "long_run");
        end
        step(1'b0, 1'b0, "long_run_end");

        // Mid-sequence reset discards pending 1s
        step(1'b1, 1'b0, "mid_pre");
        step(1'b1, 1'b0, "mid_pre");
        step(1'b1, 1'b1, "mid_rst");
        step(1'b1, 1'b0, "mid_post1");
        step(1'b1, 1'b0, "mid_post2");
        step(1'b1, 1'b0, "mid_post3");
        step(1'b0, 1'b0, "mid_end");

        // Reset from the match state with in=1
        step(1'b1, 1'b0, "s3_pre");
        step(1'b1, 1'b0, "s3_pre");
        step(1'b1, 1'b0, "s3_match");
        step(1'b1, 1'b0, "s3_hold");
        step(1'b1, 1'b1, "s3_rst");
        step(1'b1, 1'b0, "s3_after");
        step(1'b0, 1'b0, "s3_end");

        // Random stream biased toward 1s, with occasional resets
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sequence_111
